// File: rtl/rxfifo_pkg.sv
// Shared definitions for the RS232 receive FIFO: capture FSM encoding,
// default geometry/flow-control marks and status-word bit positions.
package rxfifo_pkg;

    localparam int DEPTH_DEF   = 16;
    localparam int HI_MARK_DEF = 12;
    localparam int LO_MARK_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } cap_state_t;

    // Bit positions in the I/O address 3 status word.
    localparam int STAT_RDY   = 0;
    localparam int STAT_RDYTX = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVR   = 3;

endpackage

// File: rtl/rxfifo_ram.sv
// DEPTH x 8 storage: synchronous write, asynchronous (combinational) read.
module rxfifo_ram #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [7:0]               wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [7:0]               rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rs232_rx_fifo.sv
// RS232 receive FIFO: acks each byte via rdy/done (push visible after the capture edge), FWFT read side,
// overrun drops bytes when full and sets sticky ovr. Optional RTS hysteresis under RXFIFO_RTS_EN.
module rs232_rx_fifo
    import rxfifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
`ifdef RXFIFO_RTS_EN
    ,
    parameter int HI_MARK = HI_MARK_DEF,
    parameter int LO_MARK = LO_MARK_DEF
`endif
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [7:0]               rx_data_i,
    input  logic                     rx_rdy_i,
    output logic                     rx_done_o,
    input  logic                     rd_i,
    input  logic                     clr_i,
    output logic [7:0]               dout_o,
    output logic                     rdy_o,
    output logic                     full_o,
    output logic                     ovr_o,
    output logic [$clog2(DEPTH):0]   level_o
`ifdef RXFIFO_RTS_EN
    ,
    output logic                     rts_n_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    cap_state_t      state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            rdy_q, full_q, ovr_q, ovr_d, rx_done_q, rx_done_d;
    logic            capture, push, pop, drop;
    logic [7:0]      ram_rdata;

    assign capture = (state_q == ST_IDLE) && rx_rdy_i;
    assign pop     = rd_i && rdy_q;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push    = capture && (!full_q || pop);
    assign drop    = capture && !push;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (rx_rdy_i) state_d = ST_ACK;
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_done_d = (state_d == ST_ACK);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovr_d    = ovr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            ovr_d    = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      level_d = level_q + 1'b1;
            else if (pop && !push) level_d = level_q - 1'b1;
            if (drop) ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rdy_q     <= 1'b0;
            full_q    <= 1'b0;
            ovr_q     <= 1'b0;
            rx_done_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rdy_q     <= (level_d != '0);
            full_q    <= (level_d == LW'(DEPTH));
            ovr_q     <= ovr_d;
            rx_done_q <= rx_done_d;
        end
    end

    rxfifo_ram #(.DEPTH(DEPTH)) u_ram (
        .clk_i   (clk_i),
        .we_i    (push && !clr_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (rx_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign dout_o    = rdy_q ? ram_rdata : 8'h00;
    assign rdy_o     = rdy_q;
    assign full_o    = full_q;
    assign ovr_o     = ovr_q;
    assign level_o   = level_q;
    assign rx_done_o = rx_done_q;

`ifdef RXFIFO_RTS_EN
    logic rts_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rts_q <= 1'b0;
        end else if (level_q >= LW'(HI_MARK)) begin
            rts_q <= 1'b1;
        end else if (level_q <= LW'(LO_MARK)) begin
            rts_q <= 1'b0;
        end
    end

    assign rts_n_o = rts_q;
`endif

endmodule

// File: doc/rs232_rx_fifo.md
# rs232_rx_fifo

Receive-side byte buffer between the `RS232R` receiver and the CPU I/O read mux at I/O address 2/3. It acknowledges each received byte through the receiver's `rdy`/`done` handshake and stores it in a first-word-fall-through FIFO. The CPU then drains the FIFO with data-register reads. It reports not-empty, full and a sticky overrun flag for the status word, and can optionally drive an RTS flow-control line.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥4.
- `HI_MARK`, 12: level at which RTS is deasserted (`RXFIFO_RTS_EN` only).
- `LO_MARK`, 4: level at which RTS is reasserted; must be < `HI_MARK`.
- `clk`  in  1  system clock (same 25 MHz `clk` as CPU and `RS232R`).
- `rst`  in  1  synchronous reset, active-high.
- `rx_data`  in  8  byte from receiver; valid while `rx_rdy`.
- `rx_rdy`  in  1  receiver has a byte; held until `rx_done`.
- `rx_done`  out  1  one-cycle acknowledge pulse to receiver `done`.
- `rd`  in  1  CPU read strobe of data register (`rd & ioenb & iowadr==2`); pops head.
- `clr`  in  1  one-cycle flush request (control-register write).
- `dout`  out  8  FIFO head byte; 0 when empty.
- `rdy`  out  1  FIFO not empty.
- `full`  out  1  level == `DEPTH`.
- `ovr`  out  1  sticky overrun flag.
- `level`  out  $clog2(DEPTH)+1  current occupancy.
- `rts_n`  out  1  active-low clear-to-send to host (present only with `RXFIFO_RTS_EN`).

## Operation
- Capture FSM states:
  - IDLE: `rx_rdy`=1 → go to ACK. On the same edge, push `rx_data` if a slot is free; otherwise drop the byte and set `ovr`.
  - ACK: `rx_done`=1 for this cycle → HOLD.
  - HOLD: one guard cycle so the receiver deasserts `rdy` → IDLE.
- A slot counts as free if not full, or if `rd` pops in the same cycle; in that case push and pop both occur and `level` is unchanged.
- Read side:
  - `dout` = mem[rd_ptr] when `rdy`, else 0.
  - `rd` with `rdy`=1 advances `rd_ptr` and decrements `level`.
  - `rd` when empty is ignored.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `level` is one bit wider so it can distinguish full from empty.
- `clr` resets both pointers, `level` and `ovr`, and takes priority over a push or pop in the same cycle (a byte pushed that cycle is discarded). The FSM is not reset, so an in-progress ACK/HOLD still completes its `rx_done`.
- `ovr` is set only on a dropped byte. It is cleared only by `clr` or `rst`.
- Status word packing (in the top level, not this block): {`ovr`, `full`, `rdyTx`, `rdy`} in bits [3:0] of address 3.

## Timing
- Reset values:
  - `rx_done`=0, `dout`=0, `rdy`=0, `full`=0, `ovr`=0, `level`=0, `rts_n`=0.
  - FSM in IDLE; pointers 0.
- Reset mid-handshake: the FSM returns to IDLE. The receiver still holds `rdy`, so the byte is re-captured after reset deasserts.
- Latency: `rx_rdy` sampled high in IDLE at edge N → `rdy`/`level` updated after edge N. `rx_done` is high in cycle N+1.
- Throughput: one byte per 3 cycles maximum.
- `rd` pop is visible on `dout`/`level` after the edge at which `rd` is sampled. The CPU samples `dout` in the same cycle it asserts `rd`.
- All outputs are registered except `dout`, which is a mux of registered memory and `rdy`.

## Configuration
- `RXFIFO_RTS_EN` defined: port `rts_n` exists and is registered with hysteresis.
  - It goes to 1 the cycle after `level` becomes ≥ `HI_MARK`.
  - It returns to 0 the cycle after `level` becomes ≤ `LO_MARK`.
  - Otherwise it holds its value.
- `RXFIFO_RTS_EN` undefined: no `rts_n` port, no hysteresis logic; `HI_MARK`/`LO_MARK` are unused.

## Structure
- Shared package `rxfifo_pkg`:
  - FSM state encoding (IDLE=2'd0, ACK=2'd1, HOLD=2'd2).
  - Default `DEPTH`/`HI_MARK`/`LO_MARK` constants.
  - Status bit index constants.
- One sub-module, `rxfifo_ram`: `DEPTH`×8 memory with a synchronous write port and an asynchronous read port (distributed RAM on ECP5).
- The FSM, pointers, flags and RTS logic stay in the top `rs232_rx_fifo`.

## Test plan
- Reset, then `rx_rdy`=1 with `rx_data`=8'hA5 → `rx_done` is a single pulse two cycles later; `rdy`=1, `dout`=8'hA5, `level`=1; `rd` → `rdy`=0, `dout`=0.
- Push 16 bytes 8'h00..8'h0F with no reads → `full`=1, `level`=16. A 17th byte 8'hFF → still acknowledged, `ovr`=1, FIFO unchanged. Reads return 00..0F in order; `ovr` stays 1 until `clr`.
- Level at 16 with a byte arriving in the same cycle as `rd` → byte accepted, `ovr`=0, `level` stays 16. Wrap check: last read after a full drain returns the newest byte.
- `clr` in the same cycle as a push, with `level`=5 → `level`=0, `ovr`=0. The in-flight `rx_done` still pulses; no stale data appears on `dout`.
- `rst` asserted during ACK while `rx_rdy` is held → all outputs at reset values. One cycle after release, the byte is re-captured with exactly one `rx_done`.
- `RXFIFO_RTS_EN`: fill to 12 → `rts_n`=1 one cycle later. Drain to 5 → `rts_n` stays 1. Drain to 4 → `rts_n`=0.
